// File: rtl/mo1000_pkg.sv
// Shared constants and helpers for the MO1000 DAC loopback checker.
package mo1000_pkg;

    // Checker state encoding; the value 3 is unused and recovers to HUNT.
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    // Words per transmitted frame and the number of low data bits giving the frame position.
    localparam int unsigned FRAME_LEN   = 4;
    localparam int unsigned FRAME_POS_W = $clog2(FRAME_LEN);

    // The transmitter raises its frame marker exactly on words whose frame position is zero.
    function automatic logic frame_mark(input logic [FRAME_POS_W-1:0] pos);
        return pos == '0;
    endfunction

endpackage

// File: rtl/mo1000_loopback_checker_if.sv
// Bundle of the checker's data-path and status signals.
interface mo1000_loopback_checker_if #(
    parameter int unsigned DATA_W = 16
);
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              frame;
    logic              clr_cnt;
    logic [1:0]        state;
    logic              locked;
    logic              err_pulse;
    logic [31:0]       word_cnt;
    logic [31:0]       err_cnt;

    // Source of the loopback words and the counter clear.
    modport master (
        output valid, data, frame, clr_cnt,
        input  state, locked, err_pulse, word_cnt, err_cnt
    );

    // The checker side.
    modport slave (
        input  valid, data, frame, clr_cnt,
        output state, locked, err_pulse, word_cnt, err_cnt
    );
endinterface

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        increment,
    output logic [31:0] value
);
    logic [31:0] value_q;

    // Clear wins over a coincident increment so the cleared value reads zero next cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            value_q <= '0;
        end else if (increment && (value_q != 32'hFFFF_FFFF)) begin
            value_q <= value_q + 32'd1;
        end
    end

    assign value = value_q;
endmodule

// File: rtl/mo1000_loopback_checker.sv
// Checks an incrementing-ramp loopback pattern with framing, locks onto it and keeps statistics.
module mo1000_loopback_checker
    import mo1000_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned LOCK_CNT   = 16,
    parameter int unsigned UNLOCK_CNT = 4
) (
    input  logic              i_SysClk_p,
    input  logic              i_SysRst_p,
    input  logic              i_Valid_p,
    input  logic [DATA_W-1:0] iv_Data_p,
    input  logic              i_Frame_p,
    input  logic              i_ClrCnt_p,
    output logic [1:0]        ov2_State_p,
    output logic              o_Locked_p,
    output logic              o_ErrPulse_p,
    output logic [31:0]       ov32_WordCnt_p,
    output logic [31:0]       ov32_ErrCnt_p
);
    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned BAD_W  = $clog2(UNLOCK_CNT + 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   exp_q, exp_d;
    logic [GOOD_W-1:0]   good_q, good_d, good_inc;
    logic [BAD_W-1:0]    bad_q, bad_d, bad_inc;
    logic                err_pulse_q, err_pulse_d;
    logic                locked_q;
    logic                word_good;
    logic                hunt_start;
    logic                word_inc;
    logic                err_inc;

    assign word_good  = i_Valid_p && (iv_Data_p == exp_q) &&
                        (i_Frame_p == frame_mark(exp_q[FRAME_POS_W-1:0]));
    assign hunt_start = i_Valid_p && i_Frame_p && frame_mark(iv_Data_p[FRAME_POS_W-1:0]);
    assign good_inc   = good_q + GOOD_W'(1);
    assign bad_inc    = bad_q + BAD_W'(1);

    // Next-state, expected-value tracking and per-word statistics strobes.
    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        good_d      = good_q;
        bad_d       = bad_q;
        err_pulse_d = 1'b0;
        word_inc    = 1'b0;
        err_inc     = 1'b0;
        unique case (state_q)
            HUNT: begin
                if (hunt_start) begin
                    exp_d   = iv_Data_p + DATA_W'(1);
                    good_d  = GOOD_W'(1);
                    bad_d   = '0;
                    state_d = (LOCK_CNT <= 1) ? LOCKED : VERIFY;
                end
            end
            VERIFY: begin
                if (i_Valid_p) begin
                    if (word_good) begin
                        exp_d  = exp_q + DATA_W'(1);
                        good_d = good_inc;
                        if (good_inc == GOOD_W'(LOCK_CNT)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        good_d  = '0;
                        state_d = HUNT;
                    end
                end
            end
            LOCKED: begin
                // Expected always advances here so an isolated corrupted word does not slip.
                if (i_Valid_p) begin
                    exp_d    = exp_q + DATA_W'(1);
                    word_inc = 1'b1;
                    if (word_good) begin
                        bad_d = '0;
                    end else begin
                        err_inc     = 1'b1;
                        err_pulse_d = 1'b1;
                        if (bad_inc == BAD_W'(UNLOCK_CNT)) begin
                            bad_d   = '0;
                            good_d  = '0;
                            state_d = HUNT;
                        end else begin
                            bad_d = bad_inc;
                        end
                    end
                end
            end
            default: begin
                state_d = HUNT;
                exp_d   = '0;
                good_d  = '0;
                bad_d   = '0;
            end
        endcase
    end

    // State and tracking registers; reset clears everything regardless of other inputs.
    always_ff @(posedge i_SysClk_p) begin
        if (i_SysRst_p) begin
            state_q     <= HUNT;
            exp_q       <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            err_pulse_q <= err_pulse_d;
            locked_q    <= (state_d == LOCKED);
        end
    end

    sat_counter32 u_word_cnt (
        .clk       (i_SysClk_p),
        .rst       (i_SysRst_p),
        .clear     (i_ClrCnt_p),
        .increment (word_inc),
        .value     (ov32_WordCnt_p)
    );

    sat_counter32 u_err_cnt (
        .clk       (i_SysClk_p),
        .rst       (i_SysRst_p),
        .clear     (i_ClrCnt_p),
        .increment (err_inc),
        .value     (ov32_ErrCnt_p)
    );

    assign ov2_State_p  = state_q;
    assign o_Locked_p   = locked_q;
    assign o_ErrPulse_p = err_pulse_q;
endmodule

// File: tb/tb_mo1000_loopback_checker.sv
// Scoreboard bench for the MO1000 loopback checker using directed ramp scenarios.
module tb_mo1000_loopback_checker;
    localparam logic [1:0] S_HUNT   = 2'd0;
    localparam logic [1:0] S_VERIFY = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    typedef struct {
        logic [1:0]  st;
        logic        ep;
        int unsigned wc;
        int unsigned ec;
    } exp_t;

    logic clk;
    logic rst;

    mo1000_loopback_checker_if #(.DATA_W(16)) lb ();

    mo1000_loopback_checker #(
        .DATA_W     (16),
        .LOCK_CNT   (16),
        .UNLOCK_CNT (4)
    ) dut (
        .i_SysClk_p     (clk),
        .i_SysRst_p     (rst),
        .i_Valid_p      (lb.valid),
        .iv_Data_p      (lb.data),
        .i_Frame_p      (lb.frame),
        .i_ClrCnt_p     (lb.clr_cnt),
        .ov2_State_p    (lb.state),
        .o_Locked_p     (lb.locked),
        .o_ErrPulse_p   (lb.err_pulse),
        .ov32_WordCnt_p (lb.word_cnt),
        .ov32_ErrCnt_p  (lb.err_cnt)
    );

    exp_t  pend_q[$];
    string pend_n[$];
    int    total = 0;
    int    bad   = 0;

    // Expected outputs after the word currently being driven.
    logic [1:0]  st_e = S_HUNT;
    logic        ep_e = 1'b0;
    int unsigned wc_e = 0;
    int unsigned ec_e = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s.%s: got %0h want %0h", nm, fld, act, req);
        end
    endtask

    // Monitor: entries issued before a rising edge are compared on the following falling edge.
    initial begin
        exp_t  grab[$];
        string gname[$];
        forever begin
            @(posedge clk);
            grab  = pend_q;
            gname = pend_n;
            pend_q.delete();
            pend_n.delete();
            @(negedge clk);
            foreach (grab[i]) begin
                chk(gname[i], "state", longint'(lb.state), longint'(grab[i].st));
                chk(gname[i], "locked", longint'(lb.locked), longint'(grab[i].st == S_LOCKED));
                chk(gname[i], "errpulse", longint'(lb.err_pulse), longint'(grab[i].ep));
                chk(gname[i], "wordcnt", longint'(lb.word_cnt), longint'(grab[i].wc));
                chk(gname[i], "errcnt", longint'(lb.err_cnt), longint'(grab[i].ec));
            end
        end
    end

    // Drive one cycle and record the response expected one cycle later.
    task automatic drive(input logic v, input logic [15:0] d, input logic f,
                         input logic clr, input logic r, input string nm);
        exp_t e;
        @(negedge clk);
        lb.valid   = v;
        lb.data    = d;
        lb.frame   = f;
        lb.clr_cnt = clr;
        rst        = r;
        e.st = st_e;
        e.ep = ep_e;
        e.wc = wc_e;
        e.ec = ec_e;
        pend_q.push_back(e);
        pend_n.push_back(nm);
    endtask

    // Clean ramp of n valid words; from HUNT the 16th good word locks and the 17th is counted.
    task automatic ramp(input logic [15:0] start, input int n, input bit pre_locked,
                        input bit rnd, input string nm);
        logic [15:0] d;
        int          k;
        int          guard;
        bit          v;
        d     = start;
        k     = 0;
        guard = 0;
        ep_e  = 1'b0;
        while (k < n && guard < 2000) begin
            guard++;
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (v) begin
                if (pre_locked || k >= 16) wc_e++;
                st_e = (pre_locked || k >= 15) ? S_LOCKED : S_VERIFY;
                drive(1'b1, d, d[1:0] == 2'd0, 1'b0, 1'b0, nm);
                d++;
                k++;
            end else begin
                drive(1'b0, 16'hDEAD, 1'b1, 1'b0, 1'b0, {nm, "_idle"});
            end
        end
        if (k < n) begin
            total++;
            bad++;
            $display("FAIL %s: ramp budget expired after %0d valid words, required %0d",
                     nm, k, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        rst        = 1'b1;
        lb.valid   = 1'b0;
        lb.data    = '0;
        lb.frame   = 1'b0;
        lb.clr_cnt = 1'b0;

        // Reset wins over a valid frame-start word.
        st_e = S_HUNT; ep_e = 1'b0; wc_e = 0; ec_e = 0;
        drive(1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, "reset");
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, "post_reset");

        // Lock-up on 0x0000..0x00FF: LOCKED after 0x000F, 240 words counted.
        ramp(16'h0000, 256, 1'b0, 1'b0, "ramp_lock");

        // Single corrupted word while LOCKED.
        ramp(16'h0100, 16'h23, 1'b1, 1'b0, "ramp_pre_err");
        st_e = S_LOCKED; ep_e = 1'b1; wc_e++; ec_e++;
        drive(1'b1, 16'h0923, 1'b0, 1'b0, 1'b0, "single_err");
        ramp(16'h0124, 12, 1'b1, 1'b0, "ramp_post_err");

        // Four consecutive bad words drop the lock.
        for (int i = 0; i < 4; i++) begin
            d = 16'h0130 + 16'(i);
            st_e = (i == 3) ? S_HUNT : S_LOCKED;
            ep_e = 1'b1; wc_e++; ec_e++;
            drive(1'b1, d ^ 16'h8000, d[1:0] == 2'd0, 1'b0, 1'b0, "bad_burst");
        end
        ep_e = 1'b0;
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, "hunt_idle");

        // Relock near the top and wrap through 0xFFFC..0x0003 without errors.
        ramp(16'hFFE0, 36, 1'b0, 1'b0, "ramp_wrap");

        // Reset from LOCKED, then lock with Valid toggling randomly.
        st_e = S_HUNT; ep_e = 1'b0; wc_e = 0; ec_e = 0;
        drive(1'b1, 16'h0004, 1'b0, 1'b0, 1'b1, "reset_locked");
        ramp(16'h0040, 20, 1'b0, 1'b1, "ramp_rnd_valid");

        // Clear coinciding with a counted word, then reset mid-frame.
        st_e = S_LOCKED; wc_e = 0; ec_e = 0;
        drive(1'b1, 16'h0054, 1'b1, 1'b1, 1'b0, "clr_cnt");
        wc_e = 1;
        drive(1'b1, 16'h0055, 1'b0, 1'b0, 1'b0, "after_clr");
        st_e = S_HUNT; wc_e = 0;
        drive(1'b1, 16'h0056, 1'b0, 1'b1, 1'b1, "reset_mid_frame");
        drive(1'b1, 16'h0057, 1'b0, 1'b0, 1'b0, "hunt_nonframe");
        ramp(16'h0200, 20, 1'b0, 1'b0, "ramp_relock");

        @(negedge clk);
        lb.valid = 1'b0;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
